// File: rtl/weight_bank_ram_pkg.sv
// Shared definitions for the weight bank RAM: default geometry, FSM states
// and the maximal-length LFSR tap table for weight widths 8..16.
package weight_pkg;

    localparam int unsigned DEF_DW    = 10;
    localparam int unsigned DEF_DEPTH = 64;
    localparam int unsigned DEF_LANES = 10;

    typedef enum logic {
        IDLE,
        INIT
    } state_t;

    // Tap mask for a left-shifting Fibonacci LFSR: bit k set means x^(k+1) is a tap.
    function automatic logic [15:0] lfsr_taps(input int unsigned dw);
        case (dw)
            8:       lfsr_taps = 16'h00B8;  // x^8+x^6+x^5+x^4+1
            9:       lfsr_taps = 16'h0110;  // x^9+x^5+1
            10:      lfsr_taps = 16'h0240;  // x^10+x^7+1
            11:      lfsr_taps = 16'h0500;  // x^11+x^9+1
            12:      lfsr_taps = 16'h0829;  // x^12+x^6+x^4+x+1
            13:      lfsr_taps = 16'h100D;  // x^13+x^4+x^3+x+1
            14:      lfsr_taps = 16'h2015;  // x^14+x^5+x^3+x+1
            15:      lfsr_taps = 16'h6000;  // x^15+x^14+1
            16:      lfsr_taps = 16'hD008;  // x^16+x^15+x^13+x^4+1
            default: lfsr_taps = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/weight_bank_ram_if.sv
// Request/response bundle between the training controller and the weight bank.
interface weight_bank_ram_if
    import weight_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned AW    = $clog2(DEF_DEPTH)
);
    logic                 Init;
    logic                 InitMode;
    logic                 Req;
    logic                 WE;
    logic [AW-1:0]        Address;
    logic signed [DW-1:0] D [LANES];
    logic signed [DW-1:0] Q [LANES];
    logic                 QValid;
    logic                 Busy;
    logic                 InitDone;
    logic                 AddrErr;

    modport master (
        output Init, InitMode, Req, WE, Address, D,
        input  Q, QValid, Busy, InitDone, AddrErr
    );

    modport slave (
        input  Init, InitMode, Req, WE, Address, D,
        output Q, QValid, Busy, InitDone, AddrErr
    );
endinterface

// File: rtl/weight_bank_ram_lfsr.sv
// Fibonacci LFSR producing pseudo-random initial weights; advances only when enabled.
module weight_lfsr
    import weight_pkg::*;
#(
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned SEED = 'h1A5
) (
    input  logic          Clock,
    input  logic          Rst,
    input  logic          en,
    output logic [DW-1:0] value
);
    localparam logic [15:0]   TAPS_ALL = lfsr_taps(DW);
    localparam logic [DW-1:0] TAPS     = TAPS_ALL[DW-1:0];
    localparam logic [DW-1:0] SEED_W   = DW'(SEED);

    if (TAPS == '0) begin : g_bad_dw
        $error("weight_lfsr: no tap table entry for DW=%0d", DW);
    end
    if (SEED_W == '0) begin : g_bad_seed
        $error("weight_lfsr: SEED truncates to zero");
    end

    logic [DW-1:0] r_state;
    logic          w_fb;

    assign w_fb  = ^(r_state & TAPS);
    assign value = r_state;

    // State register: reseeds on reset, shifts feedback in when enabled.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            r_state <= SEED_W;
        end else if (en) begin
            r_state <= {r_state[DW-2:0], w_fb};
        end
    end
endmodule

// File: rtl/weight_bank_ram.sv
// Weight bank RAM: LANES-wide burst read/write with modulo-DEPTH wrap and a
// self-timed zero/LFSR initialisation sweep.
// Optional macro WEIGHT_INIT_SCALE_EN: LFSR fill values are arithmetically
// shifted right by INIT_SHIFT for small-magnitude initial weights.
module weight_bank_ram
    import weight_pkg::*;
#(
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned SEED       = 'h1A5,
    parameter int unsigned INIT_SHIFT = 2
) (
    input  logic             Clock,
    input  logic             Rst,
    weight_bank_ram_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    if (LANES > DEPTH) begin : g_bad_lanes
        $error("weight_bank_ram: LANES (%0d) exceeds DEPTH (%0d)", LANES, DEPTH);
    end
    if (DW < 8 || DW > 16) begin : g_bad_dw
        $error("weight_bank_ram: DW (%0d) outside 8..16", DW);
    end
    if (INIT_SHIFT >= DW) begin : g_bad_shift
        $error("weight_bank_ram: INIT_SHIFT (%0d) must be below DW", INIT_SHIFT);
    end

    state_t               r_state, w_next;
    logic [AW-1:0]        r_cnt;
    logic                 r_mode;
    logic signed [DW-1:0] r_mem [DEPTH];
    logic signed [DW-1:0] r_q   [LANES];
    logic                 r_qvalid;
    logic                 r_addr_err;

    logic [AW:0]          w_sum [LANES];
    logic [AW-1:0]        w_idx [LANES];
    logic                 w_addr_ok;
    logic                 w_start, w_wr, w_rd, w_rej, w_init_wr, w_last;
    logic [DW-1:0]        w_lfsr;
    logic signed [DW-1:0] w_fill;

    // Power-of-two depth makes every address legal; otherwise range-check it.
    if (DEPTH == (1 << AW)) begin : g_pow2
        assign w_addr_ok = 1'b1;
    end else begin : g_npow2
        assign w_addr_ok = ({1'b0, bus.Address} < (AW+1)'(DEPTH));
    end

    // Per-lane word index, wrapped modulo DEPTH (sum is always below 2*DEPTH).
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            w_sum[i] = {1'b0, bus.Address} + (AW+1)'(i);
            w_idx[i] = (w_sum[i] >= (AW+1)'(DEPTH)) ? AW'(w_sum[i] - (AW+1)'(DEPTH))
                                                    : w_sum[i][AW-1:0];
        end
    end

    // Next-state and per-cycle action decode; Init wins over Req in IDLE.
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_wr      = 1'b0;
        w_rd      = 1'b0;
        w_rej     = 1'b0;
        w_init_wr = 1'b0;
        w_last    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.Init) begin
                    w_next  = INIT;
                    w_start = 1'b1;
                end else if (bus.Req) begin
                    if (!w_addr_ok) begin
                        w_rej = 1'b1;
                    end else if (bus.WE) begin
                        w_wr = 1'b1;
                    end else begin
                        w_rd = 1'b1;
                    end
                end
            end
            INIT: begin
                w_init_wr = 1'b1;
                if (r_cnt == AW'(DEPTH - 1)) begin
                    w_last = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // FSM state, sweep counter and latched fill mode.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_cnt  <= '0;
                r_mode <= bus.InitMode;
            end else if (w_init_wr) begin
                r_cnt <= r_cnt + AW'(1);
            end
        end
    end

    weight_lfsr #(
        .DW   (DW),
        .SEED (SEED)
    ) u_lfsr (
        .Clock (Clock),
        .Rst   (Rst),
        .en    (w_init_wr & r_mode),
        .value (w_lfsr)
    );

`ifdef WEIGHT_INIT_SCALE_EN
    assign w_fill = r_mode ? ($signed(w_lfsr) >>> INIT_SHIFT) : '0;
`else
    assign w_fill = r_mode ? $signed(w_lfsr) : '0;
`endif

    // Weight array: cleared on reset, written by the sweep or a burst write.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_init_wr) begin
            r_mem[r_cnt] <= w_fill;
        end else if (w_wr) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                r_mem[w_idx[i]] <= bus.D[i];
            end
        end
    end

    // Read data register and one-cycle status pulses.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                r_q[i] <= '0;
            end
            r_qvalid   <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_qvalid   <= w_rd;
            r_addr_err <= w_rej;
            if (w_rd) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    r_q[i] <= r_mem[w_idx[i]];
                end
            end
        end
    end

    assign bus.Q        = r_q;
    assign bus.QValid   = r_qvalid;
    assign bus.AddrErr  = r_addr_err;
    assign bus.Busy     = (r_state == INIT);
    assign bus.InitDone = w_last;
endmodule

// File: tb/tb_weight_bank_ram.sv
// Scoreboard bench for weight_bank_ram (DW=10, DEPTH=64, LANES=10).
module tb_weight_bank_ram;
    localparam int DW    = 10;
    localparam int DEPTH = 64;
    localparam int LANES = 10;
    localparam int AW    = 6;
    localparam logic [DW-1:0] SEED_V = 10'h1A5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    weight_bank_ram_if #(.DW(DW), .LANES(LANES), .AW(AW)) bus ();

    weight_bank_ram #(
        .DW         (DW),
        .DEPTH      (DEPTH),
        .LANES      (LANES),
        .SEED       ('h1A5),
        .INIT_SHIFT (2)
    ) dut (
        .Clock (clk),
        .Rst   (rst_n),
        .bus   (bus)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    int            model_mem [DEPTH];
    logic [DW-1:0] model_lfsr = SEED_V;
    int            exp_q [$];
    int            wdat [LANES];
    int            qv_pulses = 0;
    int            addr_err_seen = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
        return {s[DW-2:0], s[9] ^ s[6]};
    endfunction

    function automatic int lfsr_weight(input logic [DW-1:0] s);
        logic signed [DW-1:0] sv;
        sv = s;
`ifdef WEIGHT_INIT_SCALE_EN
        return int'(sv) >>> 2;
`else
        return int'(sv);
`endif
    endfunction

    // Scoreboard: each QValid pops one burst of expected lanes.
    always @(negedge clk) begin
        if (bus.QValid === 1'b1) begin
            qv_pulses++;
            if (exp_q.size() < LANES) begin
                check_val("qvalid_unexpected", 1, 0);
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    check_val($sformatf("q_lane%0d", i), int'(bus.Q[i]), exp_q.pop_front());
                end
            end
        end
        if (bus.AddrErr === 1'b1) addr_err_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) model_mem[k] = 0;
        model_lfsr = SEED_V;
    endtask

    task automatic do_write(input int addr);
        bus.Req = 1'b1; bus.WE = 1'b1; bus.Address = AW'(addr);
        for (int i = 0; i < LANES; i++) bus.D[i] = DW'(wdat[i]);
        tick();
        bus.Req = 1'b0; bus.WE = 1'b0;
        for (int i = 0; i < LANES; i++) model_mem[(addr + i) % DEPTH] = wdat[i];
    endtask

    task automatic do_read(input int addr);
        for (int i = 0; i < LANES; i++) exp_q.push_back(model_mem[(addr + i) % DEPTH]);
        bus.Req = 1'b1; bus.WE = 1'b0; bus.Address = AW'(addr);
        tick();
        bus.Req = 1'b0;
    endtask

    task automatic readback_all();
        for (int a = 0; a < DEPTH; a += LANES) do_read(a);
        idle(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < LANES; i++)
            check_val($sformatf("%s_q%0d", tag, i), int'(bus.Q[i]), 0);
        check_val({tag, "_qvalid"},   int'(bus.QValid),   0);
        check_val({tag, "_busy"},     int'(bus.Busy),     0);
        check_val({tag, "_initdone"}, int'(bus.InitDone), 0);
        check_val({tag, "_addrerr"},  int'(bus.AddrErr),  0);
    endtask

    // Runs one init sweep; optional same-cycle Req, mid-sweep contention, or reset.
    task automatic sweep(input logic mode, input bit inject, input int reset_at, input bit with_req);
        int busy_cycles;
        int done_at;
        int err0;
        int qv0;
        busy_cycles = 0; done_at = -1; err0 = addr_err_seen; qv0 = qv_pulses;
        bus.Init = 1'b1; bus.InitMode = mode;
        if (with_req) begin
            bus.Req = 1'b1; bus.WE = 1'b1; bus.Address = AW'(2);
            for (int i = 0; i < LANES; i++) bus.D[i] = DW'(77);
        end
        tick();
        bus.Init = 1'b0; bus.Req = 1'b0; bus.WE = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (bus.Busy !== 1'b1) break;
            busy_cycles++;
            if (bus.InitDone === 1'b1) done_at = busy_cycles;
            if (busy_cycles == reset_at) begin
                rst_n = 1'b0;
                #1;
                break;
            end
            bus.Req = 1'b0; bus.WE = 1'b0; bus.Init = 1'b0;
            if (inject && busy_cycles == 10) begin
                bus.Req = 1'b1; bus.WE = 1'b1; bus.Address = AW'(3);
                for (int i = 0; i < LANES; i++) bus.D[i] = DW'(333);
            end
            if (inject && busy_cycles == 30) begin
                bus.Init = 1'b1; bus.InitMode = ~mode;
            end
            tick();
        end
        bus.Req = 1'b0; bus.WE = 1'b0; bus.Init = 1'b0;
        if (reset_at > 0) begin
            check_reset_outputs("midinit_rst");
            tick();
            rst_n = 1'b1;
            model_clear();
        end else begin
            check_val("sweep_busy_cycles", busy_cycles, DEPTH);
            check_val("sweep_initdone_cycle", done_at, DEPTH);
            check_val("sweep_addrerr", addr_err_seen - err0, 0);
            check_val("sweep_qvalid", qv_pulses - qv0, 0);
            for (int k = 0; k < DEPTH; k++) begin
                model_mem[k] = mode ? lfsr_weight(model_lfsr) : 0;
                if (mode) model_lfsr = lfsr_step(model_lfsr);
            end
        end
    endtask

    initial begin
        int qv0;
        bus.Init = 1'b0; bus.InitMode = 1'b0; bus.Req = 1'b0; bus.WE = 1'b0;
        bus.Address = '0;
        for (int i = 0; i < LANES; i++) bus.D[i] = '0;
        model_clear();

        // Power-on reset
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        tick();
        rst_n = 1'b1;
        tick();

        // Burst write at 5, read-after-write, offset read
        for (int i = 0; i < LANES; i++) wdat[i] = i - 4;
        do_write(5);
        qv0 = qv_pulses;
        do_read(5);
        idle(3);
        check_val("qvalid_single_pulse", qv_pulses - qv0, 1);
        do_read(6);
        idle(2);
        for (int i = 0; i < LANES; i++) wdat[i] = 200 + i;
        do_write(30);
        idle(1);
        check_val("q_hold", int'(bus.Q[0]), -3);

        // Wrap-around burst
        for (int i = 0; i < LANES; i++) wdat[i] = 100 + i;
        do_write(60);
        do_read(0);
        do_read(56);
        idle(2);

        // Reset mid-run
        rst_n = 1'b0;
        #1 check_reset_outputs("midrun_rst");
        tick();
        rst_n = 1'b1;
        model_clear();
        do_read(0);
        do_read(60);
        do_read(30);
        idle(2);

        // LFSR sweep with write and Init attempts while busy
        sweep(1'b1, 1'b1, 0, 1'b0);
        readback_all();

        // Second LFSR sweep continues the sequence
        sweep(1'b1, 1'b0, 0, 1'b0);
        readback_all();

        // Init and Req together: Req dropped, zero sweep runs
        sweep(1'b0, 1'b0, 0, 1'b1);
        readback_all();

        // Fill, then reset at sweep cycle 20, then a clean zero sweep
        sweep(1'b1, 1'b0, 0, 1'b0);
        sweep(1'b1, 1'b0, 20, 1'b0);
        readback_all();
        sweep(1'b0, 1'b0, 0, 1'b0);
        readback_all();

        // After reset the LFSR restarts from SEED
        sweep(1'b1, 1'b0, 0, 1'b0);
        readback_all();

        idle(3);
        check_val("scoreboard_drained", exp_q.size(), 0);
        check_val("addrerr_never", addr_err_seen, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
